// File: rtl/shift_cfg_queue.sv
// Input stage for the variable bit shifter: absorbs configuration packets into the
// shift-amount register and queues data packets, each tagged with the shift amount in force.
module shift_cfg_queue #(
  parameter int                    ADDR_SIZE    = 4,
  parameter int                    PAYLOAD_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0]  CONFIG_ADDR  = 4'b0000,
  parameter int                    NUM_ENTRIES  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   recv_val,
  output logic                                   recv_rdy,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]        recv_msg,
  output logic                                   deq_val,
  input  logic                                   deq_rdy,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]        queue_out_msg,
  output logic [4:0]                             ctrl,
  output logic [4:0]                             cfg_shamt,
  output logic [$clog2(NUM_ENTRIES):0]           num_free
);

  localparam int W  = ADDR_SIZE + PAYLOAD_SIZE + 1;
  localparam int PW = $clog2(NUM_ENTRIES);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH    = CW'(NUM_ENTRIES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [W+4:0]    mem_r [NUM_ENTRIES];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [4:0]      cfg_shamt_r;

  logic            full_s;
  logic            empty_s;
  logic            is_cfg_s;
  logic            accept_s;
  logic            enq_s;
  logic            deq_s;
  logic [W+4:0]    head_s;

  // Handshake qualification; readiness depends on occupancy only.
  always_comb begin
    full_s   = (count_r == DEPTH);
    empty_s  = (count_r == {CW{1'b0}});
    is_cfg_s = recv_msg[W-1] && (recv_msg[W-2:PAYLOAD_SIZE] == CONFIG_ADDR);
    accept_s = recv_val && !full_s;
    enq_s    = accept_s && !is_cfg_s;
    deq_s    = deq_rdy && !empty_s;
  end

  // Pointers, occupancy and the shift-amount register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      cfg_shamt_r <= 5'd0;
    end else begin
      if (accept_s && is_cfg_s) begin
        cfg_shamt_r <= recv_msg[4:0];
      end
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage; the tag is the shift amount before this edge's update.
  always_ff @(posedge clk) begin
    if (enq_s && !reset) begin
      mem_r[wr_ptr_r] <= {recv_msg, cfg_shamt_r};
    end
  end

  // Head entry is forced to zero when the queue holds nothing.
  always_comb begin
    if (empty_s) begin
      head_s = {(W+5){1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  assign recv_rdy      = !full_s;
  assign deq_val       = !empty_s;
  assign queue_out_msg = head_s[W+4:5];
  assign ctrl          = head_s[4:0];
  assign cfg_shamt     = cfg_shamt_r;
  assign num_free      = DEPTH - count_r;

endmodule

// File: tb/tb_shift_cfg_queue.sv
// Randomized and directed bench for shift_cfg_queue against a queue-based reference model.
module tb_shift_cfg_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val;
  logic        recv_rdy;
  logic [12:0] recv_msg;
  logic        deq_val;
  logic        deq_rdy;
  logic [12:0] queue_out_msg;
  logic [4:0]  ctrl;
  logic [4:0]  cfg_shamt;
  logic [2:0]  num_free;

  shift_cfg_queue dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .deq_val(deq_val), .deq_rdy(deq_rdy),
    .queue_out_msg(queue_out_msg), .ctrl(ctrl),
    .cfg_shamt(cfg_shamt), .num_free(num_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] msg;
    logic [4:0]  tag;
  } ent_t;

  ent_t       q[$];
  logic [4:0] shamt_m = 5'd0;
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: drive, compare every output with the model, then advance the model.
  task automatic cycle(input logic rv, input logic [12:0] m, input logic dr, input logic rs);
    logic [12:0] exp_msg;
    logic [4:0]  exp_ctrl;
    logic        acc, deq, iscfg;
    int          n;
    @(negedge clk);
    reset = rs; recv_val = rv; recv_msg = m; deq_rdy = dr;
    #1;
    n = q.size();
    exp_msg  = (n > 0) ? q[0].msg : 13'd0;
    exp_ctrl = (n > 0) ? q[0].tag : 5'd0;
    check_eq("recv_rdy",  {31'd0, recv_rdy}, {31'd0, n < 4});
    check_eq("deq_val",   {31'd0, deq_val},  {31'd0, n > 0});
    check_eq("out_msg",   {19'd0, queue_out_msg}, {19'd0, exp_msg});
    check_eq("ctrl",      {27'd0, ctrl},      {27'd0, exp_ctrl});
    check_eq("cfg_shamt", {27'd0, cfg_shamt}, {27'd0, shamt_m});
    check_eq("num_free",  {29'd0, num_free},  32'(4 - n));
    iscfg = m[12] && (m[11:8] == 4'h0);
    @(posedge clk);
    if (rs) begin
      q.delete();
      shamt_m = 5'd0;
    end else begin
      acc = rv && (n < 4);
      deq = dr && (n > 0);
      if (deq) void'(q.pop_front());
      if (acc && iscfg) shamt_m = m[4:0];
      else if (acc) q.push_back('{m, shamt_m});
    end
  endtask

  function automatic logic [12:0] rand_msg();
    logic [12:0] m;
    m = 13'($urandom);
    if ($urandom_range(0, 3) == 0) m[12:8] = 5'b1_0000;
    return m;
  endfunction

  initial begin
    reset = 1'b1; recv_val = 1'b0; recv_msg = 13'd0; deq_rdy = 1'b0;
    cycle(1'b0, 13'd0, 1'b0, 1'b1);
    cycle(1'b0, 13'd0, 1'b0, 1'b0);
    #1;
    check_eq("rst_rdy",   {31'd0, recv_rdy}, 32'd1);
    check_eq("rst_dval",  {31'd0, deq_val},  32'd0);
    check_eq("rst_ctrl",  {27'd0, ctrl},     32'd0);
    check_eq("rst_shamt", {27'd0, cfg_shamt}, 32'd0);
    check_eq("rst_free",  {29'd0, num_free}, 32'd4);

    // Config then data
    cycle(1'b1, 13'h1003, 1'b0, 1'b0);
    #1;
    check_eq("cfg_free",  {29'd0, num_free}, 32'd4);
    check_eq("cfg_shamt3", {27'd0, cfg_shamt}, 32'd3);
    cycle(1'b1, 13'h05AA, 1'b0, 1'b0);
    #1;
    check_eq("lat_dval", {31'd0, deq_val}, 32'd1);
    check_eq("lat_msg",  {19'd0, queue_out_msg}, 32'h05AA);
    check_eq("lat_ctrl", {27'd0, ctrl}, 32'd3);
    cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Tag retention across a config change
    cycle(1'b1, 13'h0311, 1'b0, 1'b0);
    cycle(1'b1, 13'h1007, 1'b0, 1'b0);
    cycle(1'b1, 13'h0422, 1'b0, 1'b0);
    #1;
    check_eq("d1_ctrl", {27'd0, ctrl}, 32'd3);
    cycle(1'b0, 13'd0, 1'b1, 1'b0);
    #1;
    check_eq("d2_ctrl", {27'd0, ctrl}, 32'd7);
    check_eq("d2_msg",  {19'd0, queue_out_msg}, 32'h0422);
    cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Fill, hold off a fifth packet, then free one slot
    for (int i = 0; i < 4; i++) cycle(1'b1, 13'h0100 + 13'(i), 1'b0, 1'b0);
    #1;
    check_eq("full_rdy",  {31'd0, recv_rdy}, 32'd0);
    check_eq("full_free", {29'd0, num_free}, 32'd0);
    cycle(1'b1, 13'h1009, 1'b0, 1'b0);
    #1;
    check_eq("held_shamt", {27'd0, cfg_shamt}, 32'd7);
    cycle(1'b1, 13'h1009, 1'b1, 1'b0);
    #1;
    check_eq("after_deq_rdy", {31'd0, recv_rdy}, 32'd1);
    check_eq("after_deq_free", {29'd0, num_free}, 32'd1);
    cycle(1'b1, 13'h1009, 1'b0, 1'b0);
    #1;
    check_eq("fifth_shamt", {27'd0, cfg_shamt}, 32'd9);
    for (int i = 0; i < 4; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Streaming at occupancy two
    cycle(1'b1, 13'h0A01, 1'b0, 1'b0);
    cycle(1'b1, 13'h0A02, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 13'h0B00 + 13'(i), 1'b1, 1'b0);
      #1;
      check_eq("stream_free", {29'd0, num_free}, 32'd2);
    end
    cycle(1'b0, 13'd0, 1'b1, 1'b0);
    cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Flagged packet to a non-config address is data; then reset mid-operation
    cycle(1'b1, 13'h1007, 1'b0, 1'b0);
    cycle(1'b1, 13'h1512, 1'b0, 1'b0);
    #1;
    check_eq("addr5_msg", {19'd0, queue_out_msg}, 32'h1512);
    check_eq("addr5_shamt", {27'd0, cfg_shamt}, 32'd7);
    cycle(1'b1, 13'h0033, 1'b0, 1'b0);
    cycle(1'b1, 13'h0044, 1'b0, 1'b0);
    cycle(1'b1, 13'h0055, 1'b1, 1'b1);
    #1;
    check_eq("mid_rst_dval",  {31'd0, deq_val},   32'd0);
    check_eq("mid_rst_free",  {29'd0, num_free},  32'd4);
    check_eq("mid_rst_shamt", {27'd0, cfg_shamt}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_msg(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_cfg_queue.md
Name: shift_cfg_queue

Overview:
- Input stage that sits directly upstream of the variable bit shifter in the packet routing interconnect.
- Accepts packets over a val/rdy interface and filters out configuration packets addressed to CONFIG_ADDR. Their payload sets the shift amount.
- Buffers all other packets in a FIFO, tagging each entry with the shift amount that was in force when it was enqueued.
- Drives queue_out_msg and ctrl to the shifter, plus a val/rdy dequeue handshake.

Parameters:
- ADDR_SIZE, 4, address field width
- PAYLOAD_SIZE, 8, payload field width (must be >= 5)
- CONFIG_ADDR, 4'b0000, address that marks a configuration packet
- NUM_ENTRIES, 4, FIFO depth (power of two, >= 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- recv_val  input  1  upstream packet valid
- recv_rdy  output  1  this block can accept a packet
- recv_msg  input  ADDR_SIZE+PAYLOAD_SIZE+1  incoming packet
- deq_val  output  1  head entry valid
- deq_rdy  input  1  shifter consumes head entry this cycle
- queue_out_msg  output  ADDR_SIZE+PAYLOAD_SIZE+1  head packet, to the shifter
- ctrl  output  5  shift amount tagged on the head packet, to the shifter
- cfg_shamt  output  5  current configuration register value
- num_free  output  clog2(NUM_ENTRIES)+1  free FIFO entries

Behaviour:
- Packet fields, with W = ADDR_SIZE+PAYLOAD_SIZE+1:
  - msg[W-1]: cfg flag
  - msg[W-2:PAYLOAD_SIZE]: address
  - msg[PAYLOAD_SIZE-1:0]: payload
- A config packet has cfg flag = 1 and address == CONFIG_ADDR. Every other packet is a data packet, including cfg flag = 1 with any other address.
- Reset: FIFO empty, read/write pointers 0, cfg_shamt = 0.
  - Resulting outputs: recv_rdy = 1, deq_val = 0, queue_out_msg = 0, ctrl = 0, num_free = NUM_ENTRIES.
  - A reset mid-operation discards all entries and clears cfg_shamt on the same edge.
  - Handshakes in the reset cycle are ignored.
- recv_rdy = !full (full = count == NUM_ENTRIES). It is a function of state only and does not depend on recv_val or recv_msg.
- Accept condition: recv_val && recv_rdy.
  - Config packet accepted: cfg_shamt <= payload[4:0] on the edge. Nothing is enqueued.
  - Data packet accepted: write {recv_msg, cfg_shamt} at the write pointer, then increment it.
  - The tag is the pre-edge cfg_shamt, so a config packet always affects strictly later data packets.
- Config packets are also blocked while full. They are never dropped.
- Dequeue: deq_val = !empty. On deq_val && deq_rdy the read pointer increments.
- queue_out_msg and ctrl come from the head entry. When empty, both are 0.
- Latency: a data packet accepted at edge N is at the head and visible at cycle N+1 when the FIFO was empty. There is no combinational bypass.
- Simultaneous accept and dequeue:
  - Not full: count unchanged, both pointers advance.
  - Full: recv_rdy = 0, so only the dequeue happens and recv_rdy = 1 the next cycle.
  - Empty: deq_val = 0, so only the enqueue happens.
- Pointers wrap modulo NUM_ENTRIES. count ranges 0..NUM_ENTRIES; num_free = NUM_ENTRIES - count.
- Entries already queued keep their tagged ctrl when cfg_shamt later changes.
- Shift value stored unmodified (0..31). Range handling is the shifter's responsibility.
- deq_rdy while empty has no effect. recv_val while not ready has no effect; upstream must hold its packet.

Test Plan:
- Reset then idle. Required: recv_rdy=1, deq_val=0, ctrl=0, cfg_shamt=0, num_free=4.
- Send config 0x1_0_03 (flag 1, addr 0, payload 0x03), then data 0x0_5_AA. Required: nothing enqueued after the config packet; cfg_shamt=3. One cycle after the data accept: deq_val=1, queue_out_msg=0x05AA, ctrl=3.
- Enqueue data D1; send config payload 7; enqueue D2 with deq_rdy=0. Then dequeue both. Required: D1 leaves with ctrl=3, D2 leaves with ctrl=7.
- Fill 4 data packets with deq_rdy=0. Required: recv_rdy=0, num_free=0, and a 5th packet (config or data) is held off. Raise deq_rdy for one cycle with recv_val=1. Required: only the dequeue happens; the next cycle recv_rdy=1 and the 5th packet is accepted.
- Stream 10 packets with simultaneous enqueue and dequeue at count 2. Required: count stays 2, pointers wrap, output order matches input order.
- Flag 1 with addr 5 → enqueued as data. Then assert reset with 3 entries queued and cfg_shamt=7. Required: next cycle deq_val=0, num_free=4, cfg_shamt=0.
